// File: rtl/cp_phase_gen.sv
// Two-phase non-overlapping clock generator driving the analog charge pump.
// phi1/phi2 are flop outputs decoded from the next FSM state, so they are
// glitch-free. Both phases fall asynchronously when rst is asserted.
// When the synchronised comparator says the pump output is at target, the
// generator skips whole cycles by parking in HOLD.
module cp_phase_gen #(
   parameter int DIV_W = 8,
   parameter int DT_W  = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [DIV_W-1:0] div,
   input  logic [DT_W-1:0]  dt,
   input  logic             comp_in,
   output logic             phi1,
   output logic             phi2,
   output logic             running,
   output logic             regulated,
   output logic [CNT_W-1:0] cycle_cnt
);

   // The down-counter must hold either a full phase length or a dead time.
   localparam int CW = (DIV_W > DT_W) ? DIV_W : DT_W;
   localparam logic [DT_W-1:0]  DT_ONE  = DT_W'(1);
   localparam logic [CW-1:0]    CNT_ONE = CW'(1);
   localparam logic [CNT_W-1:0] CYC_ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      P1   = 3'd1,
      DT1  = 3'd2,
      P2   = 3'd3,
      DT2  = 3'd4,
      HOLD = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [DIV_W-1:0] div_l_q, div_l_d;
   logic [DT_W-1:0]  dt_l_q, dt_l_d;
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic             phi1_q, phi1_d;
   logic             phi2_q, phi2_d;
   logic             running_q, running_d;
   logic             ena_q;
   logic             sync1_q;
   logic             comp_s_q;
   logic             enter_p1;

   // Input sampling: two-flop synchroniser for the async comparator and a
   // sampling flop for the run enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         comp_s_q <= 1'b0;
         ena_q    <= 1'b0;
      end else begin
         sync1_q  <= comp_in;
         comp_s_q <= sync1_q;
         ena_q    <= ena;
      end
   end

   // Next-state logic: phase sequencing, dead-time counting, cycle skipping.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      div_l_d     = div_l_q;
      dt_l_d      = dt_l_q;
      cycle_cnt_d = cycle_cnt_q;
      enter_p1    = 1'b0;

      if (!ena_q) begin
         // Disable aborts mid-cycle; nothing is finished.
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (comp_s_q) state_d = HOLD;
               else          enter_p1 = 1'b1;
            end
            P1: begin
               if (cnt_q == '0) begin
                  state_d = DT1;
                  cnt_d   = CW'(dt_l_q - DT_ONE);
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            DT1: begin
               if (cnt_q == '0) begin
                  state_d = P2;
                  cnt_d   = CW'(div_l_q);
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            P2: begin
               if (cnt_q == '0) begin
                  state_d = DT2;
                  cnt_d   = CW'(dt_l_q - DT_ONE);
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            DT2: begin
               if (cnt_q == '0) begin
                  if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + CYC_ONE;
                  // Regulation is only honoured at a cycle boundary.
                  if (comp_s_q) state_d = HOLD;
                  else          enter_p1 = 1'b1;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            HOLD: begin
               if (!comp_s_q) enter_p1 = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end

      // Every P1 entry captures a fresh configuration; P1 itself uses the
      // live div so the new value applies from this phase on.
      if (enter_p1) begin
         state_d = P1;
         div_l_d = div;
         dt_l_d  = (dt == '0) ? DT_ONE : dt;
         cnt_d   = CW'(div);
      end

      phi1_d    = (state_d == P1);
      phi2_d    = (state_d == P2);
      running_d = (state_d != IDLE);
   end

   // FSM, counters, latched config and registered phase outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         div_l_q     <= '0;
         dt_l_q      <= DT_ONE;
         cycle_cnt_q <= '0;
         phi1_q      <= 1'b0;
         phi2_q      <= 1'b0;
         running_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         div_l_q     <= div_l_d;
         dt_l_q      <= dt_l_d;
         cycle_cnt_q <= cycle_cnt_d;
         phi1_q      <= phi1_d;
         phi2_q      <= phi2_d;
         running_q   <= running_d;
      end
   end

   assign phi1      = phi1_q;
   assign phi2      = phi2_q;
   assign running   = running_q;
   assign regulated = comp_s_q;
   assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cp_phase_gen.sv
// Directed bench for cp_phase_gen: expected phase patterns are queued as the
// stimulus is applied and compared cycle by cycle as the DUT produces them.
module tb_cp_phase_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        ena, comp_in;
   logic [7:0]  div;
   logic [3:0]  dt;
   logic        phi1, phi2, running, regulated;
   logic [15:0] cycle_cnt;

   logic        ena_b;
   logic [7:0]  div_b;
   logic [3:0]  dt_b;
   logic        comp_b;
   logic        phi1_b, phi2_b, running_b, regulated_b;
   logic [3:0]  cycle_cnt_b;

   int checks = 0;
   int errors = 0;
   logic [1:0] exp_q[$];   // {phi1, phi2} expected per cycle

   cp_phase_gen #(.DIV_W(8), .DT_W(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .ena(ena), .div(div), .dt(dt), .comp_in(comp_in),
      .phi1(phi1), .phi2(phi2), .running(running), .regulated(regulated),
      .cycle_cnt(cycle_cnt)
   );

   cp_phase_gen #(.DIV_W(8), .DT_W(4), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .ena(ena_b), .div(div_b), .dt(dt_b), .comp_in(comp_b),
      .phi1(phi1_b), .phi2(phi2_b), .running(running_b), .regulated(regulated_b),
      .cycle_cnt(cycle_cnt_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_run(input logic [1:0] v, input int n);
      repeat (n) exp_q.push_back(v);
   endtask

   task automatic push_period(input int d, input int t, input int n);
      int tl;
      tl = (t == 0) ? 1 : t;
      repeat (n) begin
         push_run(2'b10, d + 1);
         push_run(2'b00, tl);
         push_run(2'b01, d + 1);
         push_run(2'b00, tl);
      end
   endtask

   task automatic check_phase(input string tag);
      logic [1:0] e;
      step();
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed=empty-queue expected=entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk(tag, {30'd0, phi1, phi2}, {30'd0, e});
         chk({tag, "_overlap"}, {31'd0, phi1 & phi2}, 32'd0);
      end
   endtask

   task automatic drain(input string tag);
      while (exp_q.size() > 0) check_phase(tag);
   endtask

   task automatic wait_for_phi2(input string tag);
      int n;
      n = 0;
      while (phi2 !== 1'b1 && n < 1000) begin
         step();
         n++;
      end
      chk(tag, {31'd0, phi2}, 32'd1);
   endtask

   task automatic stop_run(input string tag);
      ena = 1'b0;
      step();
      step();
      chk({tag, "_running"}, {31'd0, running}, 32'd0);
      chk({tag, "_phases"}, {30'd0, phi1, phi2}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; ena = 1'b0; comp_in = 1'b0; div = 8'd2; dt = 4'd1;
      ena_b = 1'b0; div_b = 8'd0; dt_b = 4'd0; comp_b = 1'b0;
      step();
      step();
      chk("rst_phi1", {31'd0, phi1}, 32'd0);
      chk("rst_phi2", {31'd0, phi2}, 32'd0);
      chk("rst_running", {31'd0, running}, 32'd0);
      chk("rst_regulated", {31'd0, regulated}, 32'd0);
      chk("rst_cnt", {16'd0, cycle_cnt}, 32'd0);
      rst = 1'b0;
      step();

      // Basic waveform, div=2 dt=1: 10 periods of 8 cycles.
      exp_q.push_back(2'b00);
      push_period(2, 1, 10);
      ena = 1'b1;
      drain("basic");
      step();
      chk("basic_cnt", {16'd0, cycle_cnt}, 32'd10);
      chk("basic_p1_again", {31'd0, phi1}, 32'd1);

      // Enable drop during P2: the cycle is abandoned.
      wait_for_phi2("drop_wait");
      ena = 1'b0;
      step();
      chk("drop_phi2_hold", {31'd0, phi2}, 32'd1);
      chk("drop_running_hold", {31'd0, running}, 32'd1);
      step();
      chk("drop_phi2", {31'd0, phi2}, 32'd0);
      chk("drop_running", {31'd0, running}, 32'd0);
      chk("drop_cnt", {16'd0, cycle_cnt}, 32'd10);

      // Dead-time clamp: dt=0, div=0 gives a period of 4.
      div = 8'd0; dt = 4'd0;
      exp_q.push_back(2'b00);
      push_period(0, 0, 5);
      ena = 1'b1;
      drain("clamp");
      stop_run("clamp_stop");
      chk("clamp_cnt", {16'd0, cycle_cnt}, 32'd15);

      // Config change mid-P1: current cycle keeps div=2, next uses div=4.
      div = 8'd2; dt = 4'd1;
      exp_q.push_back(2'b00);
      push_run(2'b10, 3); push_run(2'b00, 1); push_run(2'b01, 3); push_run(2'b00, 1);
      push_run(2'b10, 5); push_run(2'b00, 1); push_run(2'b01, 5); push_run(2'b00, 1);
      ena = 1'b1;
      check_phase("cfg");
      check_phase("cfg");
      div = 8'd4;
      drain("cfg");
      stop_run("cfg_stop");
      chk("cfg_cnt", {16'd0, cycle_cnt}, 32'd17);

      // Regulation: comp_in rises mid-P2, cycle completes, then HOLD.
      div = 8'd2; dt = 4'd1;
      ena = 1'b1;
      wait_for_phi2("reg_wait");
      comp_in = 1'b1;
      push_run(2'b01, 2);
      push_run(2'b00, 1);
      drain("reg_finish");
      for (int i = 0; i < 4; i++) begin
         step();
         chk("hold_phases", {30'd0, phi1, phi2}, 32'd0);
         chk("hold_running", {31'd0, running}, 32'd1);
         chk("hold_regulated", {31'd0, regulated}, 32'd1);
      end
      chk("hold_cnt", {16'd0, cycle_cnt}, 32'd18);
      comp_in = 1'b0;
      step();
      chk("resume_e1", {31'd0, phi1}, 32'd0);
      step();
      chk("resume_e2", {31'd0, phi1}, 32'd0);
      chk("resume_regulated", {31'd0, regulated}, 32'd0);
      step();
      chk("resume_e3", {31'd0, phi1}, 32'd1);
      stop_run("reg_stop");

      // Maximum config: 256-cycle phases, 15-cycle gaps.
      div = 8'd255; dt = 4'd15;
      exp_q.push_back(2'b00);
      push_period(255, 15, 1);
      ena = 1'b1;
      drain("max");
      stop_run("max_stop");
      chk("max_cnt", {16'd0, cycle_cnt}, 32'd19);

      // Asynchronous reset mid-P1 with div=5.
      div = 8'd5; dt = 4'd1;
      ena = 1'b1;
      step();
      step();
      step();
      chk("arst_pre_phi1", {31'd0, phi1}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_phi1", {31'd0, phi1}, 32'd0);
      chk("arst_phi2", {31'd0, phi2}, 32'd0);
      chk("arst_running", {31'd0, running}, 32'd0);
      chk("arst_cnt", {16'd0, cycle_cnt}, 32'd0);
      ena = 1'b0;
      step();
      rst = 1'b0;
      step();

      // Counter saturation with a 4-bit cycle counter, period 4.
      ena_b = 1'b1;
      repeat (30) step();
      chk("sat_mid", {28'd0, cycle_cnt_b}, 32'd7);
      repeat (70) step();
      chk("sat_full", {28'd0, cycle_cnt_b}, 32'd15);
      repeat (20) step();
      chk("sat_hold", {28'd0, cycle_cnt_b}, 32'd15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cp_phase_gen.md
Name: cp_phase_gen

Overview:
- Digital driver for the analog charge pump core.
- Generates a programmable two-phase, non-overlapping clock pair (phi1/phi2) with configurable half-period and dead time.
- Supports pulse-skipping regulation from the pump's output comparator.
- Sits directly upstream of the analog pump; phi1/phi2 drive its switch/capacitor phases through analog-pin buffers.

Parameters:
- DIV_W, 8: width of the half-period config; phase high time = div+1 clk cycles.
- DT_W, 4: width of the dead-time config.
- CNT_W, 16: width of the completed-cycle counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  run enable, synchronous level.
- div  in  DIV_W  phase high time minus 1, in clk cycles.
- dt  in  DT_W  dead time in clk cycles; 0 is treated as 1.
- comp_in  in  1  asynchronous comparator output; 1 = pump output at or above target.
- phi1  out  1  pump phase 1 drive.
- phi2  out  1  pump phase 2 drive.
- running  out  1  high while the FSM is not in IDLE.
- regulated  out  1  synchronised comp_in.
- cycle_cnt  out  CNT_W  count of completed phi1+phi2 cycles, saturating.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. rst=1 asynchronously clears all state, with these values:
  - FSM = IDLE.
  - phi1 = phi2 = 0, running = 0, regulated = 0.
  - cycle_cnt = 0, synchroniser flops = 0.
  - Reset mid-operation drops both phases immediately.
- comp_in passes through a 2-flop synchroniser. comp_s is the second flop; regulated = comp_s.
- FSM states: IDLE, P1, DT1, P2, DT2, HOLD.
- phi1 and phi2 are flop outputs decoded from registered state: phi1 = (state==P1), phi2 = (state==P2). They are glitch-free and never simultaneously 1.
- Config latch: div_l and dt_l (dt_l = max(dt,1)) are captured on every transition into P1. div/dt changes mid-cycle take effect at the next P1 entry.
- A down-counter cnt is loaded on each state entry: div_l for P1/P2, dt_l-1 for DT1/DT2. A state exits when cnt==0.
- Transitions, evaluated at each rising edge in priority order:
  1. ena=0: from any state -> IDLE at the next edge, so phases are low the cycle after ena is sampled low. Do not finish the current cycle.
  2. IDLE: ena=1 and comp_s=0 -> P1; ena=1 and comp_s=1 -> HOLD.
  3. P1 with cnt==0 -> DT1; DT1 with cnt==0 -> P2; P2 with cnt==0 -> DT2.
  4. DT2 with cnt==0: increment cycle_cnt (saturates at 2^CNT_W-1). Then comp_s=1 -> HOLD, else -> P1.
  5. HOLD: both phases low; comp_s=0 -> P1.
- comp_s is sampled only at DT2 exit and in IDLE/HOLD. A cycle is never truncated by regulation.
- Timing:
  - Phase high time = div+1 cycles. Dead time = max(dt,1) cycles.
  - Period = 2*(div+1) + 2*max(dt,1).
  - ena 0->1 sampled at edge k gives phi1=1 after edge k+1.
- running = (state != IDLE), registered with the state.
- div=0 gives 1-cycle phases. div all-ones gives 2^DIV_W-cycle phases; the counter must not overflow.

Test Plan:
- Reset/idle: assert rst mid-P1 with div=5 -> phi1, phi2, running and cycle_cnt read 0 asynchronously, without waiting for a clk edge.
- Basic waveform: div=2, dt=1, comp_in=0, ena=1 -> phi1 high 3 cycles, 1 low, phi2 high 3 cycles, 1 low. Period is 8 cycles. Check phi1&phi2 is never 1 and cycle_cnt=10 after 80 cycles.
- Dead-time clamp and max config:
  - dt=0, div=0 -> phi1 1 cycle, gap 1, phi2 1 cycle, gap 1, period 4.
  - div=255, dt=15 -> phases 256 cycles, gaps 15 cycles.
- Regulation skip: raise comp_in mid-P2 -> current cycle completes, then HOLD (both low, running=1). Drop comp_in -> phi1 rises 3 edges later: 2 synchroniser edges plus 1 transition edge.
- Enable drop and config change:
  - ena=0 during P2 -> phi2=0 and running=0 one cycle after the sampling edge.
  - Change div 2->4 mid-P1 -> the current P1 stays 3 cycles; the next P1 is 5 cycles.
- Counter saturation: CNT_W=4, run 20 cycles -> cycle_cnt holds at 15.
